chunked_seq_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, carrying the inter-chunk carry in a register, under a start/busy/done handshake. It is the sequential, width-generic successor of the 4-bit ripple-carry full adder. It trades latency for a short CHUNK-bit carry chain and adds subtract mode and signed-overflow detection.

---
 rtl/chunked_seq_adder_if.sv | 26 ++
 rtl/chunked_seq_adder.sv | 106 ++++++++++
 tb/tb_chunked_seq_adder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_seq_adder_if.sv
// Operand/result bundle for chunked_seq_adder: start/busy/done handshake plus operands and result.
// master drives the request side, slave (the adder) drives status and results.
interface chunked_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, a, b, carry_in, sub,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, a, b, carry_in, sub,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/subtract, CHUNK bits per clock; WIDTH/CHUNK cycles start-to-done, one-cycle done pulse.
// start is only taken in IDLE/DONE; a start while busy is dropped, never queued.
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  chunked_seq_adder_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic [31:0]      base;
  logic [CHUNK:0]   chunk_sum;
  logic             accept;

  assign accept    = bus.start && (state_q != RUN);
  assign base      = 32'(idx_q) * CHUNK;
  assign chunk_sum = {1'b0, op_a_q[base +: CHUNK]} + {1'b0, op_b_q[base +: CHUNK]}
                   + {{CHUNK{1'b0}}, cy_q};

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ov_d    = ov_q;

    case (state_q)
      RUN: begin
        acc_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        cy_d = chunk_sum[CHUNK];
        if (idx_q == LAST) begin
          // Index parks at 0 so the chunk select never leaves the operand range.
          idx_d   = '0;
          state_d = DONE;
          sum_d   = acc_d;
          co_d    = chunk_sum[CHUNK];
          ov_d    = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (acc_d[WIDTH-1] != op_a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Subtract is a + ~b + 1, so carry_in is replaced by the forced 1.
    if (accept) begin
      state_d = RUN;
      op_a_d  = bus.a;
      op_b_d  = bus.sub ? ~bus.b : bus.b;
      cy_d    = bus.sub ? 1'b1 : bus.carry_in;
      idx_d   = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: directed handshake/reset tests on a 16/4 instance, random sweeps on four shapes.
module tb_chunked_seq_adder;
  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ov;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst_sw_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   sweeps_done = 0;
  int   busy_run = 0;
  logic [15:0] prev_sum = '0;
  exp_t sbq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chunked_seq_adder_if #(.WIDTH(16)) dif ();
  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain WIDTH+1-bit reference add.
  function automatic exp_t ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sub);
    logic [63:0] mask, aa, bb, full;
    exp_t r;
    mask  = (64'd1 << w) - 64'd1;
    aa    = {32'b0, a} & mask;
    bb    = (sub ? ~{32'b0, b} : {32'b0, b}) & mask;
    full  = aa + bb + {63'b0, (sub ? 1'b1 : ci)};
    r.sum = 32'(full & mask);
    r.co  = full[w];
    r.ov  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    r.cyc = 0;
    return r;
  endfunction

  // Scoreboard side: pop on every done, check results, latency, busy length and result hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
      prev_sum = '0;
    end else begin
      chk("done_busy_excl", {63'b0, dif.done & dif.busy}, 64'd0);
      if (dif.busy) busy_run++;
      if (dif.done) begin
        chk("sb_nonempty", {63'b0, sbq.size() > 0}, 64'd1);
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("sum", {48'b0, dif.sum}, {48'b0, e.sum[15:0]});
          chk("carry_out", {63'b0, dif.carry_out}, {63'b0, e.co});
          chk("overflow", {63'b0, dif.overflow}, {63'b0, e.ov});
          chk("latency", 64'(cyc - e.cyc), 64'd4);
          chk("busy_cycles", 64'(busy_run), 64'd4);
          prev_sum = e.sum[15:0];
        end
        busy_run = 0;
      end else begin
        chk("sum_hold", {48'b0, dif.sum}, {48'b0, prev_sum});
      end
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub,
                       input logic [15:0] es, input logic eco, input logic eov);
    exp_t e;
    @(negedge clk);
    dif.start = 1'b1; dif.a = a; dif.b = b; dif.carry_in = ci; dif.sub = sub;
    @(posedge clk); #1;
    e.sum = {16'b0, es}; e.co = eco; e.ov = eov; e.cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic drop_start();
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_timeout", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {63'b0, dif.busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, dif.done}, 64'd0);
    chk({tag, "_sum"}, {48'b0, dif.sum}, 64'd0);
    chk({tag, "_co"}, {63'b0, dif.carry_out}, 64'd0);
    chk({tag, "_ov"}, {63'b0, dif.overflow}, 64'd0);
  endtask

  initial begin
    exp_t r;
    logic [31:0] ra, rb;
    int n;
    rst_n = 1'b0;
    dif.start = 1'b0; dif.a = '0; dif.b = '0; dif.carry_in = 1'b0; dif.sub = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    rst_n = 1'b1;

    // Carry ripples through three chunks.
    drive(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    drop_start();
    wait_empty(20);

    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drop_start();
    wait_empty(20);
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drop_start();
    wait_empty(20);

    drive(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    drop_start();
    wait_empty(20);
    drive(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drop_start();
    wait_empty(20);

    // start held high; operands scrambled while running must not matter.
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      r = ref_add(16, ra, rb, 1'b0, i == 1);
      drive(ra[15:0], rb[15:0], 1'b0, i == 1, r.sum[15:0], r.co, r.ov);
      repeat (4) begin
        @(negedge clk);
        dif.a = 16'($urandom); dif.b = 16'($urandom); dif.sub = ~dif.sub; dif.carry_in = ~dif.carry_in;
      end
    end
    @(negedge clk);
    dif.start = 1'b0;
    wait_empty(20);

    // A start pulse mid-run is dropped.
    drive(16'h9000, 16'h9000, 1'b0, 1'b0, 16'h2000, 1'b1, 1'b1);
    drop_start();
    @(negedge clk);
    dif.start = 1'b1; dif.a = 16'hFFFF; dif.b = 16'hFFFF; dif.sub = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_empty(20);

    // Abort two cycles into RUN; results must clear without a clock edge.
    @(negedge clk);
    dif.start = 1'b1; dif.a = 16'h4321; dif.b = 16'h1111; dif.sub = 1'b0; dif.carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    drop_start();
    wait_empty(20);

    n = 0;
    while (sweeps_done < 4 && n < 60000) begin
      @(posedge clk);
      n++;
    end
    chk("sweep_finished", 64'(sweeps_done), 64'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst_sw_n = 1'b0;
    #23 rst_sw_n = 1'b1;
  end

  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int W = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 12 : 32;
    localparam int C = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 12 : 8;
    localparam int N = W / C;

    chunked_seq_adder_if #(.WIDTH(W)) sif ();
    chunked_seq_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk   (clk),
      .rst_n (rst_sw_n),
      .bus   (sif.slave)
    );

    initial begin
      exp_t e;
      logic [31:0] sa, sb;
      logic sc, ss;
      int lat;
      exp_t q[$];
      sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.carry_in = 1'b0; sif.sub = 1'b0;
      wait (rst_sw_n === 1'b1);
      for (int i = 0; i < 260; i++) begin
        sa = $urandom; sb = $urandom;
        sc = 1'($urandom_range(0, 1)); ss = 1'($urandom_range(0, 1));
        @(negedge clk);
        sif.start = 1'b1; sif.a = sa[W-1:0]; sif.b = sb[W-1:0]; sif.carry_in = sc; sif.sub = ss;
        @(posedge clk); #1;
        q.push_back(ref_add(W, sa, sb, sc, ss));
        @(negedge clk);
        sif.start = 1'b0;
        lat = 0;
        while (!sif.done && lat < N + 4) begin
          @(posedge clk); #1;
          lat++;
        end
        e = q.pop_front();
        chk("sweep_latency", 64'(lat), 64'(N));
        chk("sweep_sum", {32'b0, 32'(sif.sum)}, {32'b0, e.sum});
        chk("sweep_carry_out", {63'b0, sif.carry_out}, {63'b0, e.co});
        chk("sweep_overflow", {63'b0, sif.overflow}, {63'b0, e.ov});
      end
      sweeps_done++;
    end
  end
endmodule
